axis_packet_gen: RTL

//   AXI-Stream packet transmitter (source end of the valid/last/data/ready stream bus).
//   On a start pulse it emits one packet of pkt_len beats with an incrementing data pattern from seed.
//   It marks the final beat with last, honours ready backpressure and reports completion.

---
 rtl/axis_packet_gen.sv | 78 +++++++
 1 files changed

// File: rtl/axis_packet_gen.sv
// rtl/axis_packet_gen.sv - stream packet source emitting an incrementing data pattern
// Emits pkt_len beats starting at seed on start, honours ready backpressure, counts packets.
module axis_packet_gen #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [LEN_WIDTH-1:0]      pkt_len,
    input  logic [AXI_DATA_WIDTH-1:0] seed,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_WIDTH-1:0]      pkt_cnt,
    output logic                      valid,
    output logic                      last,
    output logic [AXI_DATA_WIDTH-1:0] data,
    input  logic                      ready
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] len;
    logic [LEN_WIDTH-1:0] beat_idx;
    logic [LEN_WIDTH-1:0] next_idx;

    // beat_idx only reaches len-1, so the increment never wraps even at the maximum length
    assign next_idx = beat_idx + LEN_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            len      <= '0;
            beat_idx <= '0;
            data     <= '0;
            valid    <= 1'b0;
            last     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pkt_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (pkt_len != '0)) begin
                        len      <= pkt_len;
                        data     <= seed;
                        beat_idx <= '0;
                        last     <= (pkt_len == LEN_WIDTH'(1));
                        valid    <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (valid && ready) begin
                        if (last) begin
                            valid   <= 1'b0;
                            last    <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
                            state   <= IDLE;
                        end else begin
                            data     <= data + AXI_DATA_WIDTH'(1);
                            beat_idx <= next_idx;
                            last     <= (next_idx == len - LEN_WIDTH'(1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
